flag_branch_unit: RTL and testbench
===================================

# flag_branch_unit

Holds the processor's architectural flag register {Z,V,N} and resolves conditional branches against it. It consumes the 3-bit flag vector and 4-bit opcode that the ALU produces in EX, and answers branch requests issued from ID. EX results are forwarded into same-cycle branch evaluation. While EX is stalled, the unit holds a pending branch.

## Interface
- No parameters (fixed 16-bit ISA, 3 flags, 8 condition codes).
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  a live instruction occupies EX this cycle
- ex_busy  in  1  EX is stalled; its flags are not final
- ex_flush  in  1  the EX instruction is squashed; it must not write flags
- ex_aluop  in  4  ALU opcode of the EX instruction
- ex_flag  in  3  ALU flags, ordered {Z,V,N}
- br_req  in  1  a branch in ID requests resolution
- br_cond  in  3  condition code of that branch
- br_cancel  in  1  abort a pending or new branch request
- br_stall  out  1  hold ID; the branch cannot be resolved this cycle
- br_resp_valid  out  1  one-cycle pulse; br_taken is valid
- br_taken  out  1  branch outcome
- flag_q  out  3  current flag register {Z,V,N}

## Operation
- **Flag write enable.** A write occurs when ex_valid & !ex_busy & !ex_flush.
  - Opcodes 0000 (ADD) and 0001 (SUB) write Z, V and N.
  - Opcodes 0010 (XOR), 0100 (SLL), 0101 (SRA) and 0110 (ROR) write Z only; V and N hold.
  - All other opcodes write nothing: PADDSB, LLB, LHB, LW/SW, and the unused codes.
- **Effective flags (eff).** eff is flag_q with this cycle's enabled bits replaced by ex_flag. This is the forwarding path; it is purely combinational.
- **Conditions,** evaluated on eff:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always taken
- **FSM states:** IDLE and WAIT. A 3-bit pending condition register is loaded on entry to WAIT.
- **IDLE transitions:**
  - br_req & br_cancel: request dropped; stay in IDLE; no response.
  - br_req & !ex_busy: evaluate now; response registered for the next cycle; stay in IDLE.
  - br_req & ex_busy: latch br_cond; go to WAIT.
- **WAIT transitions:**
  - br_cancel: go to IDLE; no response. Cancel has priority over evaluation.
  - else if !ex_busy: evaluate the latched condition on eff; go to IDLE.
  - else: stay in WAIT.
  - br_req and br_cond are ignored while in WAIT.
- **br_stall** = (IDLE & br_req & ex_busy & !br_cancel) | (WAIT & !(br_cancel | !ex_busy)). It is combinational and deasserts in the evaluation cycle.
- Flag writes in the evaluation cycle are visible to that evaluation through eff.

## Timing
- **Reset values:** flag_q = 000, state = IDLE, br_resp_valid = 0, br_taken = 0, pending condition = 000. br_stall is low during reset because the state is IDLE and br_req is masked while rst is high.
- **Reset mid-WAIT:** returns to IDLE next edge; no response is issued; any flag write in that cycle is discarded.
- **Latency:** evaluation at cycle t gives br_resp_valid = 1 and br_taken at t+1.
  - br_resp_valid lasts exactly one cycle.
  - br_taken holds its value until the next response (it is not cleared).
- **Flag updates:** flag_q updates at the edge ending a write cycle.
- **Back-to-back branches:** a new br_req may be accepted in the cycle br_resp_valid is high (state is IDLE). Throughput is one branch per cycle when EX is not busy.
- **Minimum WAIT:** one cycle. A busy branch at t with ex_busy dropping at t+1 gives a response at t+2.
- **Flush and busy:** ex_flush only gates the flag write; it has no effect on the FSM. ex_busy high blocks flag writes regardless of ex_valid.

## Test plan
- **Reset and NE.** Assert rst for 2 cycles; expect flag_q=000, br_resp_valid=0. Then br_req with cond 000 and no writer; expect br_resp_valid=1, br_taken=1 next cycle.
- **SUB forwarding.** A SUB in EX with ex_flag=100 and br_req cond 001 in the same cycle. Expect taken=1 next cycle and flag_q=100.
- **Selective write.** From flag_q=011, run XOR with ex_flag=100; expect flag_q=111. Then PADDSB with ex_flag=000; expect flag_q stays 111.
- **Busy stall.** br_req cond 110 while ex_busy=1 for 3 cycles, with flag_q V=1. Expect br_stall=1 for those cycles, deasserted in the release cycle, and br_resp_valid with taken=1 one cycle after release.
- **Cancel in WAIT.** Enter WAIT as above, then pulse br_cancel. Expect IDLE next cycle, br_stall=0, and no br_resp_valid pulse.
- **Flush and rst mid-WAIT.** An ADD with ex_flush=1 and ex_flag=001 must leave flag_q unchanged. Separately, rst asserted while in WAIT must give IDLE with no response.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural {Z,V,N} flag register plus
// conditional branch resolver with EX->branch flag forwarding.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ex_valid        live instruction in EX
//   ex_busy         EX stalled, its flags are not final
//   ex_flush        EX instruction squashed, no flag write
//   ex_aluop[3:0]   ALU opcode of the EX instruction
//   ex_flag[2:0]    ALU flags {Z,V,N}
//   br_req          branch in ID requests resolution
//   br_cond[2:0]    condition code of that branch
//   br_cancel       abort a pending or new request
//   br_stall        hold ID, branch not resolvable this cycle
//   br_resp_valid   one-cycle pulse, br_taken is valid
//   br_taken        branch outcome, held until next response
//   flag_q[2:0]     flag register {Z,V,N}
module flag_branch_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic       ex_busy,
    input  logic       ex_flush,
    input  logic [3:0] ex_aluop,
    input  logic [2:0] ex_flag,
    input  logic       br_req,
    input  logic [2:0] br_cond,
    input  logic       br_cancel,
    output logic       br_stall,
    output logic       br_resp_valid,
    output logic       br_taken,
    output logic [2:0] flag_q
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] pend_cond;

    logic       wr_en;
    logic       wr_z;
    logic       wr_vn;
    logic [2:0] eff;
    logic       req;
    logic       eval;
    logic       load_pend;
    logic [2:0] cond_sel;
    logic       hit;

    // Which flag bits this opcode owns.
    always_comb begin
        wr_z  = 1'b0;
        wr_vn = 1'b0;
        unique case (ex_aluop)
            4'b0000,
            4'b0001: begin
                wr_z  = 1'b1;
                wr_vn = 1'b1;
            end
            4'b0010,
            4'b0100,
            4'b0101,
            4'b0110: wr_z = 1'b1;
            default: ;
        endcase
    end

    assign wr_en = ex_valid & ~ex_busy & ~ex_flush;

    // Forwarded flags: this cycle's writes override flag_q.
    always_comb begin
        eff = flag_q;
        if (wr_en & wr_z)
            eff[2] = ex_flag[2];
        if (wr_en & wr_vn)
            eff[1:0] = ex_flag[1:0];
    end

    // A request presented during reset is ignored.
    assign req = br_req & ~rst;

    // Output / control decode.
    always_comb begin
        br_stall  = 1'b0;
        eval      = 1'b0;
        load_pend = 1'b0;
        cond_sel  = br_cond;
        unique case (state)
            IDLE: begin
                br_stall  = req & ex_busy & ~br_cancel;
                load_pend = req & ex_busy & ~br_cancel;
                eval      = req & ~ex_busy & ~br_cancel;
            end
            WAIT: begin
                cond_sel = pend_cond;
                br_stall = ~rst & ex_busy & ~br_cancel;
                eval     = ~rst & ~ex_busy & ~br_cancel;
            end
            default: ;
        endcase
    end

    // Condition evaluation on forwarded flags.
    always_comb begin
        hit = 1'b0;
        unique case (cond_sel)
            3'b000: hit = ~eff[2];
            3'b001: hit = eff[2];
            3'b010: hit = ~eff[2] & ~eff[0];
            3'b011: hit = eff[0];
            3'b100: hit = eff[2] | ~eff[0];
            3'b101: hit = eff[0] | eff[2];
            3'b110: hit = eff[1];
            3'b111: hit = 1'b1;
            default: hit = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (load_pend)
                state_nxt = WAIT;
            WAIT: if (br_cancel | ~ex_busy)
                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q        <= 3'b000;
            pend_cond     <= 3'b000;
            br_resp_valid <= 1'b0;
            br_taken      <= 1'b0;
        end else begin
            flag_q        <= eff;
            br_resp_valid <= eval;
            if (load_pend)
                pend_cond <= br_cond;
            if (eval)
                br_taken <= hit;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed self-checking bench for
// flag_branch_unit, one task per scenario.
module tb_flag_branch_unit;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic       ex_busy;
    logic       ex_flush;
    logic [3:0] ex_aluop;
    logic [2:0] ex_flag;
    logic       br_req;
    logic [2:0] br_cond;
    logic       br_cancel;
    logic       br_stall;
    logic       br_resp_valid;
    logic       br_taken;
    logic [2:0] flag_q;

    int n_pass;
    int n_total;

    flag_branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_busy       (ex_busy),
        .ex_flush      (ex_flush),
        .ex_aluop      (ex_aluop),
        .ex_flag       (ex_flag),
        .br_req        (br_req),
        .br_cond       (br_cond),
        .br_cancel     (br_cancel),
        .br_stall      (br_stall),
        .br_resp_valid (br_resp_valid),
        .br_taken      (br_taken),
        .flag_q        (flag_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle();
        rst       = 1'b0;
        ex_valid  = 1'b0;
        ex_busy   = 1'b0;
        ex_flush  = 1'b0;
        ex_aluop  = 4'b0011;
        ex_flag   = 3'b000;
        br_req    = 1'b0;
        br_cond   = 3'b000;
        br_cancel = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op,
                       input logic [2:0] f);
        ex_valid = 1'b1;
        ex_aluop = op;
        ex_flag  = f;
    endtask

    task automatic test_reset();
        drv_idle();
        rst     = 1'b1;
        br_req  = 1'b1;
        ex_busy = 1'b1;
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL rst_stall0 got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL rst_stall1 got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        drv_idle();
        #1;
        n_total++;
        if (flag_q !== 3'b000)
            $display("FAIL rst_flag got %b want 000", flag_q);
        else
            n_pass++;
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL rst_resp got %b want 0", br_resp_valid);
        else
            n_pass++;
    endtask

    task automatic test_ne();
        br_req  = 1'b1;
        br_cond = 3'b000;
        cyc();
        drv_idle();
        n_total++;
        if ({br_resp_valid, br_taken} !== 2'b11)
            $display("FAIL ne_resp got %b%b want 11",
                     br_resp_valid, br_taken);
        else
            n_pass++;
        cyc();
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL ne_pulse got %b want 0", br_resp_valid);
        else
            n_pass++;
    endtask

    task automatic test_sub_fwd();
        alu(4'b0001, 3'b100);
        br_req  = 1'b1;
        br_cond = 3'b001;
        cyc();
        drv_idle();
        n_total++;
        if ({br_resp_valid, br_taken} !== 2'b11)
            $display("FAIL sub_fwd got %b%b want 11",
                     br_resp_valid, br_taken);
        else
            n_pass++;
        n_total++;
        if (flag_q !== 3'b100)
            $display("FAIL sub_flag got %b want 100", flag_q);
        else
            n_pass++;
    endtask

    task automatic test_selective();
        alu(4'b0000, 3'b011);
        cyc();
        n_total++;
        if (flag_q !== 3'b011)
            $display("FAIL add_flag got %b want 011", flag_q);
        else
            n_pass++;
        alu(4'b0010, 3'b100);
        cyc();
        n_total++;
        if (flag_q !== 3'b111)
            $display("FAIL xor_flag got %b want 111", flag_q);
        else
            n_pass++;
        alu(4'b0011, 3'b000);
        cyc();
        drv_idle();
        n_total++;
        if (flag_q !== 3'b111)
            $display("FAIL paddsb_flag got %b want 111", flag_q);
        else
            n_pass++;
    endtask

    task automatic test_busy_stall();
        alu(4'b0000, 3'b010);
        cyc();
        drv_idle();
        br_req  = 1'b1;
        br_cond = 3'b110;
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (br_stall !== 1'b1)
                $display("FAIL busy_stall%0d got %b want 1",
                         i, br_stall);
            else
                n_pass++;
            n_total++;
            if (br_resp_valid !== 1'b0)
                $display("FAIL busy_resp%0d got %b want 0",
                         i, br_resp_valid);
            else
                n_pass++;
            cyc();
            br_req = 1'b0;
        end
        ex_busy = 1'b0;
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL release_stall got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        n_total++;
        if ({br_resp_valid, br_taken} !== 2'b11)
            $display("FAIL busy_ov got %b%b want 11",
                     br_resp_valid, br_taken);
        else
            n_pass++;
        cyc();
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL busy_pulse got %b want 0", br_resp_valid);
        else
            n_pass++;
    endtask

    task automatic test_min_wait();
        br_req  = 1'b1;
        br_cond = 3'b001;
        ex_busy = 1'b1;
        alu(4'b0000, 3'b111);
        cyc();
        br_req  = 1'b0;
        ex_busy = 1'b0;
        alu(4'b0010, 3'b100);
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL minw_stall got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        drv_idle();
        n_total++;
        if ({br_resp_valid, br_taken} !== 2'b11)
            $display("FAIL minw_resp got %b%b want 11",
                     br_resp_valid, br_taken);
        else
            n_pass++;
        n_total++;
        if (flag_q !== 3'b110)
            $display("FAIL minw_flag got %b want 110", flag_q);
        else
            n_pass++;
    endtask

    task automatic test_cancel_wait();
        br_req  = 1'b1;
        br_cond = 3'b111;
        ex_busy = 1'b1;
        cyc();
        br_req    = 1'b0;
        br_cancel = 1'b1;
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL cancel_stall got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        br_cancel = 1'b0;
        #1;
        n_total++;
        if ({br_stall, br_resp_valid} !== 2'b00)
            $display("FAIL cancel_idle got %b%b want 00",
                     br_stall, br_resp_valid);
        else
            n_pass++;
        ex_busy = 1'b0;
        cyc();
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL cancel_resp got %b want 0", br_resp_valid);
        else
            n_pass++;
        br_req    = 1'b1;
        br_cancel = 1'b1;
        br_cond   = 3'b111;
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL idle_cancel_stall got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        drv_idle();
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL idle_cancel_resp got %b want 0",
                     br_resp_valid);
        else
            n_pass++;
    endtask

    task automatic test_flush();
        alu(4'b0000, 3'b001);
        ex_flush = 1'b1;
        cyc();
        drv_idle();
        n_total++;
        if (flag_q !== 3'b110)
            $display("FAIL flush_flag got %b want 110", flag_q);
        else
            n_pass++;
    endtask

    task automatic test_rst_wait();
        br_req  = 1'b1;
        br_cond = 3'b111;
        ex_busy = 1'b1;
        cyc();
        rst     = 1'b1;
        br_req  = 1'b0;
        ex_busy = 1'b0;
        alu(4'b0001, 3'b111);
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL rstw_stall got %b want 0", br_stall);
        else
            n_pass++;
        cyc();
        drv_idle();
        n_total++;
        if (flag_q !== 3'b000)
            $display("FAIL rstw_flag got %b want 000", flag_q);
        else
            n_pass++;
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL rstw_resp got %b want 0", br_resp_valid);
        else
            n_pass++;
        ex_busy = 1'b1;
        #1;
        n_total++;
        if (br_stall !== 1'b0)
            $display("FAIL rstw_idle got %b want 0", br_stall);
        else
            n_pass++;
        ex_busy = 1'b0;
        cyc();
        n_total++;
        if (br_resp_valid !== 1'b0)
            $display("FAIL rstw_resp2 got %b want 0", br_resp_valid);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] fl [3];
        logic [7:0] ex [3];
        fl[0] = 3'b001;
        ex[0] = 8'b1010_1001;
        fl[1] = 3'b100;
        ex[1] = 8'b1011_0010;
        fl[2] = 3'b010;
        ex[2] = 8'b1101_0101;
        for (int s = 0; s < 3; s++) begin
            drv_idle();
            alu(4'b0001, fl[s]);
            cyc();
            ex_valid = 1'b0;
            for (int c = 0; c < 8; c++) begin
                br_req  = 1'b1;
                br_cond = 3'(c);
                cyc();
                n_total++;
                if ({br_resp_valid, br_taken} !== {1'b1, ex[s][c]})
                    $display("FAIL b2b f%b c%0d got %b%b want 1%b",
                             fl[s], c, br_resp_valid, br_taken,
                             ex[s][c]);
                else
                    n_pass++;
            end
        end
        drv_idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        drv_idle();
        cyc();
        test_reset();
        test_ne();
        test_sub_fwd();
        test_selective();
        test_busy_stall();
        test_min_wait();
        test_cancel_wait();
        test_flush();
        test_rst_wait();
        test_back_to_back();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
